// File: rtl/bbox_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// bbox_scan_ctrl_if
//   Bundles the upstream box handshake and the downstream pixel stream of
//   bbox_scan_ctrl.
//
//   Upstream   : nd (in), us_rfd (out), minX/maxX/minY/maxY (in, signed)
//   Downstream : ds_rfd (in), rdy, px_x, px_y, last, pix_cnt (out)
//   Status     : empty (out), a one-cycle pulse for a box with no on-screen
//                pixels
//
//   Modport slave is the scan controller; master is whoever drives boxes
//   and consumes pixels.
// ---------------------------------------------------------------------------
interface bbox_scan_ctrl_if #(
  parameter int COORD_W = 11
);

  logic                      nd;
  logic                      us_rfd;
  logic signed [COORD_W-1:0] minX;
  logic signed [COORD_W-1:0] maxX;
  logic signed [COORD_W-1:0] minY;
  logic signed [COORD_W-1:0] maxY;

  logic                      ds_rfd;
  logic                      rdy;
  logic [9:0]                px_x;
  logic [8:0]                px_y;
  logic                      last;
  logic                      empty;
  logic [18:0]               pix_cnt;

  modport slave (
    input  nd, minX, maxX, minY, maxY, ds_rfd,
    output us_rfd, rdy, px_x, px_y, last, empty, pix_cnt
  );

  modport master (
    output nd, minX, maxX, minY, maxY, ds_rfd,
    input  us_rfd, rdy, px_x, px_y, last, empty, pix_cnt
  );

endinterface

// File: rtl/bbox_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bbox_scan_ctrl
//   Accepts one triangle bounding box at a time. It clamps the box to the
//   screen and emits every on-screen pixel of the box in row-major order over
//   a valid/ready stream.
//
//   Ports
//     clk   : single clock, rising edge
//     rst   : asynchronous, active-high reset
//     bus   : bbox_scan_ctrl_if.slave
//             nd/us_rfd + minX..maxY  box input handshake
//             rdy/ds_rfd              pixel output handshake
//             px_x, px_y, last        current pixel, last pixel of the box
//             pix_cnt                 handshakes completed for the current box
//             empty                   pulse: accepted box is fully off-screen
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a box; us_rfd=1; pix_cnt holds the last total
//   SCAN  | walking the clamped box; rdy=1; leaves after the last handshake
// ---------------------------------------------------------------------------
module bbox_scan_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COORD_W  = 11
) (
  input  logic            clk,
  input  logic            rst,
  bbox_scan_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic signed [COORD_W-1:0] ZERO   = '0;
  localparam logic signed [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

  state_e      state_q, state_d;
  logic [9:0]  px_x_q, px_x_d;
  logic [8:0]  px_y_q, px_y_d;
  logic [9:0]  x_min_q, x_min_d;
  logic [9:0]  x_max_q, x_max_d;
  logic [8:0]  y_max_q, y_max_d;
  logic [18:0] pix_cnt_q, pix_cnt_d;
  logic        empty_q, empty_d;

  logic signed [COORD_W-1:0] cmin_x, cmax_x, cmin_y, cmax_y;
  logic box_empty;
  logic at_row_end;
  logic at_last;

  // Clamp the incoming box to the screen. All compares are signed so that
  // negative bounds clamp to zero instead of wrapping to large values.
  always_comb begin
    cmin_x    = (bus.minX < ZERO)   ? ZERO   : bus.minX;
    cmax_x    = (bus.maxX > X_LAST) ? X_LAST : bus.maxX;
    cmin_y    = (bus.minY < ZERO)   ? ZERO   : bus.minY;
    cmax_y    = (bus.maxY > Y_LAST) ? Y_LAST : bus.maxY;
    box_empty = (cmin_x > cmax_x) || (cmin_y > cmax_y);
  end

  assign at_row_end = (px_x_q == x_max_q);
  assign at_last    = (state_q == SCAN) && at_row_end && (px_y_q == y_max_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      px_x_q    <= '0;
      px_y_q    <= '0;
      x_min_q   <= '0;
      x_max_q   <= '0;
      y_max_q   <= '0;
      pix_cnt_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_x_q    <= px_x_d;
      px_y_q    <= px_y_d;
      x_min_q   <= x_min_d;
      x_max_q   <= x_max_d;
      y_max_q   <= y_max_d;
      pix_cnt_q <= pix_cnt_d;
      empty_q   <= empty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    px_x_d    = px_x_q;
    px_y_d    = px_y_q;
    x_min_d   = x_min_q;
    x_max_d   = x_max_q;
    y_max_d   = y_max_q;
    pix_cnt_d = pix_cnt_q;
    empty_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.nd) begin
          if (box_empty) begin
            empty_d = 1'b1;
          end else begin
            // A non-empty clamped box lies on screen, so the low bits
            // carry the whole value.
            state_d   = SCAN;
            px_x_d    = cmin_x[9:0];
            px_y_d    = cmin_y[8:0];
            x_min_d   = cmin_x[9:0];
            x_max_d   = cmax_x[9:0];
            y_max_d   = cmax_y[8:0];
            pix_cnt_d = '0;
          end
        end
      end
      SCAN: begin
        if (bus.ds_rfd) begin
          pix_cnt_d = pix_cnt_q + 19'd1;
          if (at_last) begin
            state_d = IDLE;
          end else if (!at_row_end) begin
            px_x_d = px_x_q + 10'd1;
          end else begin
            px_x_d = x_min_q;
            px_y_d = px_y_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.us_rfd  = (state_q == IDLE);
  assign bus.rdy     = (state_q == SCAN);
  assign bus.px_x    = px_x_q;
  assign bus.px_y    = px_y_q;
  assign bus.last    = at_last;
  assign bus.empty   = empty_q;
  assign bus.pix_cnt = pix_cnt_q;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
module tb_bbox_scan_ctrl;

  localparam int SW = 40;
  localparam int SH = 30;
  localparam int CW = 11;

  typedef struct {
    int x;
    int y;
    bit last;
    int cnt;
  } pix_t;

  typedef struct {
    int mnx;
    int mxx;
    int mny;
    int mxy;
    int mode;
    bit exp_empty;
    int exp_npix;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  pix_t exp_q[$];
  pix_t mon_e;
  vec_t vecs[10];

  bbox_scan_ctrl_if #(.COORD_W(CW)) bus ();

  bbox_scan_ctrl #(
    .SCREEN_W(SW),
    .SCREEN_H(SH),
    .COORD_W (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel monitor: compares the presented pixel against the head of the
  // scoreboard every cycle rdy is high, and retires it on a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          mon_e = exp_q[0];
          chk("px_x", bus.px_x, mon_e.x);
          chk("px_y", bus.px_y, mon_e.y);
          chk("last", bus.last, mon_e.last);
          chk("pix_cnt", bus.pix_cnt, mon_e.cnt);
          if (bus.ds_rfd) exp_q.delete(0);
        end
      end else if (bus.last) begin
        chk("last_without_rdy", 1, 0);
      end
    end
  end

  task automatic push_box(input int mnx, input int mxx, input int mny, input int mxy,
                          output int n, output bit emp);
    int cx0, cx1, cy0, cy1;
    cx0 = (mnx < 0) ? 0 : mnx;
    cx1 = (mxx > SW - 1) ? SW - 1 : mxx;
    cy0 = (mny < 0) ? 0 : mny;
    cy1 = (mxy > SH - 1) ? SH - 1 : mxy;
    emp = (cx0 > cx1) || (cy0 > cy1);
    n   = 0;
    if (!emp) begin
      for (int y = cy0; y <= cy1; y++) begin
        for (int x = cx0; x <= cx1; x++) begin
          exp_q.push_back('{x: x, y: y, last: (x == cx1 && y == cy1), cnt: n});
          n++;
        end
      end
    end
  endtask

  function automatic logic ds_pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return !(k == 1 || k == 2);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic drive_bounds(input int mnx, input int mxx, input int mny, input int mxy);
    bus.minX = CW'(mnx);
    bus.maxX = CW'(mxx);
    bus.minY = CW'(mny);
    bus.maxY = CW'(mxy);
  endtask

  task automatic run_box(input vec_t v);
    int n, b, k;
    bit emp;
    b = 0;
    while (!bus.us_rfd && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) chk("wait_us_rfd_timeout", 0, 1);
    push_box(v.mnx, v.mxx, v.mny, v.mxy, n, emp);
    drive_bounds(v.mnx, v.mxx, v.mny, v.mxy);
    bus.nd     = 1'b1;
    bus.ds_rfd = 1'b1;
    tick();
    bus.nd = 1'b0;
    // Scribble on the bounds: a running scan must ignore them.
    drive_bounds($urandom_range(0, 30), $urandom_range(0, 30),
                 $urandom_range(0, 20), $urandom_range(0, 20));
    chk("empty_pulse", bus.empty, v.exp_empty);
    chk("rdy_latency", bus.rdy, !v.exp_empty);
    if (v.exp_empty) begin
      chk("us_rfd_empty", bus.us_rfd, 1);
      tick();
      chk("empty_one_cycle", bus.empty, 0);
      chk("no_rdy_empty", bus.rdy, 0);
      return;
    end
    k = 0;
    while (exp_q.size() > 0 && k < 4 * n + 50) begin
      bus.ds_rfd = ds_pat(v.mode, k);
      k++;
      tick();
    end
    if (exp_q.size() > 0) begin
      chk("scan_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    bus.ds_rfd = 1'b1;
    chk("rdy_drop", bus.rdy, 0);
    chk("us_rfd_back", bus.us_rfd, 1);
    chk("pix_total", bus.pix_cnt, v.exp_npix);
    tick();
    chk("pix_cnt_hold", bus.pix_cnt, v.exp_npix);
  endtask

  initial begin
    int n, b;
    bit emp, seen_idle;

    n_checks = 0;
    n_fail   = 0;
    rst        = 1'b1;
    bus.nd     = 1'b0;
    bus.ds_rfd = 1'b1;
    drive_bounds(0, 0, 0, 0);

    vecs[0] = '{mnx: 2,     mxx: 4,    mny: 3,  mxy: 4,  mode: 0, exp_empty: 0, exp_npix: 6};
    vecs[1] = '{mnx: -5,    mxx: 1,    mny: -2, mxy: 0,  mode: 0, exp_empty: 0, exp_npix: 2};
    vecs[2] = '{mnx: 700,   mxx: 800,  mny: 10, mxy: 20, mode: 0, exp_empty: 1, exp_npix: 0};
    vecs[3] = '{mnx: 10,    mxx: 11,   mny: 10, mxy: 10, mode: 1, exp_empty: 0, exp_npix: 2};
    vecs[4] = '{mnx: 5,     mxx: 5,    mny: 5,  mxy: 5,  mode: 2, exp_empty: 0, exp_npix: 1};
    vecs[5] = '{mnx: 3,     mxx: 2,    mny: 0,  mxy: 0,  mode: 0, exp_empty: 1, exp_npix: 0};
    vecs[6] = '{mnx: -10,   mxx: -1,   mny: 0,  mxy: 5,  mode: 0, exp_empty: 1, exp_npix: 0};
    vecs[7] = '{mnx: 0,     mxx: 39,   mny: 0,  mxy: 29, mode: 2, exp_empty: 0, exp_npix: 1200};
    vecs[8] = '{mnx: 35,    mxx: 50,   mny: 25, mxy: 40, mode: 2, exp_empty: 0, exp_npix: 25};
    vecs[9] = '{mnx: -1024, mxx: 1023, mny: 28, mxy: 29, mode: 2, exp_empty: 0, exp_npix: 80};

    // Reset values must appear before any clock edge.
    #3;
    chk("rst_us_rfd", bus.us_rfd, 1);
    chk("rst_rdy", bus.rdy, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_empty", bus.empty, 0);
    chk("rst_px_x", bus.px_x, 0);
    chk("rst_px_y", bus.px_y, 0);
    chk("rst_pix_cnt", bus.pix_cnt, 0);
    bus.nd = 1'b1;
    tick();
    tick();
    chk("rst_nd_ignored", bus.rdy, 0);
    bus.nd = 1'b0;
    rst    = 1'b0;
    tick();

    foreach (vecs[i]) run_box(vecs[i]);

    // nd held high through a whole scan with bounds changing underneath:
    // the second box is taken only once the first has finished.
    push_box(0, 3, 0, 1, n, emp);
    push_box(1, 1, 1, 1, n, emp);
    drive_bounds(0, 3, 0, 1);
    bus.nd     = 1'b1;
    bus.ds_rfd = 1'b1;
    tick();
    drive_bounds(1, 1, 1, 1);
    seen_idle = 1'b0;
    b = 0;
    while (exp_q.size() > 0 && b < 100) begin
      tick();
      b++;
      if (seen_idle) bus.nd = 1'b0;
      if (bus.us_rfd && !seen_idle) begin
        seen_idle = 1'b1;
        chk("idle_after_first_box", exp_q.size(), 1);
      end
    end
    chk("held_nd_done", exp_q.size(), 0);
    exp_q.delete();
    bus.nd = 1'b0;
    tick();
    chk("held_nd_idle", bus.us_rfd, 1);

    // Reset in the middle of a scan aborts the box.
    push_box(0, 9, 0, 9, n, emp);
    drive_bounds(0, 9, 0, 9);
    bus.nd = 1'b1;
    tick();
    bus.nd = 1'b0;
    b = 0;
    while (exp_q.size() > 97 && b < 50) begin
      tick();
      b++;
    end
    chk("three_pixels_out", exp_q.size(), 97);
    rst = 1'b1;
    #2;
    exp_q.delete();
    chk("midrst_rdy", bus.rdy, 0);
    chk("midrst_px_x", bus.px_x, 0);
    chk("midrst_px_y", bus.px_y, 0);
    chk("midrst_pix_cnt", bus.pix_cnt, 0);
    chk("midrst_us_rfd", bus.us_rfd, 1);
    tick();
    chk("midrst_rdy_hold", bus.rdy, 0);
    rst = 1'b0;
    run_box('{mnx: 5, mxx: 5, mny: 5, mxy: 5, mode: 0, exp_empty: 0, exp_npix: 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
